// File: rtl/a7_link_pkg.sv
// a7_link_pkg: shared constants and types for the A7 serial link receiver.
//   SYM_BITS          wire bits per symbol (marker + flag + 8 data + 2 stop)
//   STOP_PATTERN      required value of the two stop bits
//   STATUS_LSB        bit offset of the status byte within a response word
//   RDDATA_LSB        bit offset of the 16-bit read data within a response word
//   deframe_state_t   deframer FSM states
//   sym_frame_t       the 11 post-marker bits of one symbol, as captured
package a7_link_pkg;

  localparam int unsigned SYM_BITS         = 12;
  localparam int unsigned POST_MARKER_BITS = SYM_BITS - 1;
  localparam logic [1:0]  STOP_PATTERN     = 2'b00;
  localparam int unsigned STATUS_LSB       = 0;
  localparam int unsigned RDDATA_LSB       = 8;

  typedef enum logic [1:0] {
    HUNT,
    SHIFT,
    CHECK
  } deframe_state_t;

  typedef struct packed {
    logic       flag;
    logic [7:0] data;
    logic [1:0] stop;
  } sym_frame_t;

endpackage

// File: rtl/a7_sym_deframer.sv
// a7_sym_deframer: registers the serial line, hunts for the '1' marker,
// shifts in the 11 post-marker bits and validates the stop bits.
//   clk, reset   fabric clock, synchronous active-high reset
//   serin        serial line, idle low
//   sym_valid    one-cycle pulse per well-framed symbol
//   sym_flag     cmd flag of the symbol (valid with sym_valid)
//   sym_data     data byte of the symbol (valid with sym_valid)
//   bytes_seen   well-framed symbol count, wraps
//   frame_errs   bad-stop-bit symbol count, wraps
module a7_sym_deframer
  import a7_link_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serin,
  output logic             sym_valid,
  output logic             sym_flag,
  output logic [7:0]       sym_data,
  output logic [CNT_W-1:0] bytes_seen,
  output logic [CNT_W-1:0] frame_errs
);

  localparam logic [3:0] LAST_BIT = 4'(POST_MARKER_BITS - 1);

  logic           s;
  deframe_state_t state;
  logic [3:0]     bitcnt;
  logic [9:0]     shreg;
  sym_frame_t     frame;

  // Frame as it will look once the current sample is shifted in.
  always_comb begin
    frame = sym_frame_t'({shreg, s});
  end

  // The stop check is evaluated while the last bit is being captured so the
  // registered sym_valid is high during the CHECK cycle itself; CHECK then
  // only decides whether the sample it sees is the next symbol's marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      s          <= 1'b0;
      state      <= HUNT;
      bitcnt     <= '0;
      shreg      <= '0;
      sym_valid  <= 1'b0;
      sym_flag   <= 1'b0;
      sym_data   <= '0;
      bytes_seen <= '0;
      frame_errs <= '0;
    end else begin
      s         <= serin;
      sym_valid <= 1'b0;
      case (state)
        HUNT: begin
          if (s) begin
            state  <= SHIFT;
            bitcnt <= '0;
          end
        end
        SHIFT: begin
          shreg  <= {shreg[8:0], s};
          bitcnt <= bitcnt + 4'd1;
          if (bitcnt == LAST_BIT) begin
            state <= CHECK;
            if (frame.stop == STOP_PATTERN) begin
              sym_valid  <= 1'b1;
              sym_flag   <= frame.flag;
              sym_data   <= frame.data;
              bytes_seen <= bytes_seen + CNT_W'(1);
            end else begin
              frame_errs <= frame_errs + CNT_W'(1);
            end
          end
        end
        CHECK: begin
          // A marker arriving straight after the stop bits is taken here,
          // exactly as HUNT would have taken it.
          if (s) begin
            state  <= SHIFT;
            bitcnt <= '0;
          end else begin
            state <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: rtl/a7_link_rx.sv
// a7_link_rx: receive side of the serial bus link. Deframes symbols, builds
// the 40-bit response word, latches it on the flagged (end-of-command)
// symbol and tracks request pending / timeout state.
//   clk, reset    fabric clock, synchronous active-high reset
//   serin         serial line from the remote bus FSM
//   req_start     one-cycle pulse when a remote access is launched
//   sym_valid     one-cycle pulse per well-framed symbol
//   sym_flag      cmd flag of that symbol
//   sym_data      data byte of that symbol
//   resp_valid    one-cycle pulse when last_word is updated
//   last_word     latest response: [7:0] status, [23:8] read data
//   resp_pending  high from req_start until resp_valid or timeout
//   resp_timeout  sticky timeout flag, cleared by req_start
//   bytes_seen    well-framed symbol count
//   frame_errs    bad-stop-bit symbol count
module a7_link_rx
  import a7_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serin,
  input  logic             req_start,
  output logic             sym_valid,
  output logic             sym_flag,
  output logic [7:0]       sym_data,
  output logic             resp_valid,
  output logic [39:0]      last_word,
  output logic             resp_pending,
  output logic             resp_timeout,
  output logic [CNT_W-1:0] bytes_seen,
  output logic [CNT_W-1:0] frame_errs
);

  localparam int unsigned      TMR_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  // Only the newest four bytes can reach last_word, so older ones are not kept.
  logic [31:0]      acc;
  logic [TMR_W-1:0] timer;
  logic             flagged;

  a7_sym_deframer #(
    .CNT_W(CNT_W)
  ) u_deframer (
    .clk        (clk),
    .reset      (reset),
    .serin      (serin),
    .sym_valid  (sym_valid),
    .sym_flag   (sym_flag),
    .sym_data   (sym_data),
    .bytes_seen (bytes_seen),
    .frame_errs (frame_errs)
  );

  assign flagged = sym_valid & sym_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      last_word    <= '0;
      resp_valid   <= 1'b0;
      resp_pending <= 1'b0;
      resp_timeout <= 1'b0;
      timer        <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (req_start) begin
        // A new request discards anything in flight, including a flagged
        // symbol landing on this very cycle.
        acc          <= '0;
        last_word    <= '0;
        resp_pending <= 1'b1;
        resp_timeout <= 1'b0;
        timer        <= '0;
      end else begin
        if (sym_valid) begin
          if (sym_flag) begin
            last_word    <= {acc, sym_data};
            acc          <= '0;
            resp_valid   <= 1'b1;
            resp_pending <= 1'b0;
          end else begin
            acc <= {acc[23:0], sym_data};
          end
        end
        // A response arriving on the expiry cycle beats the timeout.
        if (resp_pending && !flagged) begin
          timer <= timer + TMR_W'(1);
          if (timer == TMR_LAST) begin
            resp_timeout <= 1'b1;
            resp_pending <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_a7_link_rx.sv
// tb_a7_link_rx: directed stimulus for a7_link_rx with a transaction-level
// reference model and per-cycle comparison of every output.
module tb_a7_link_rx;

  localparam int unsigned TO = 4096;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          serin = 1'b0;
  logic          req_start = 1'b0;
  logic          sym_valid, sym_flag, resp_valid, resp_pending, resp_timeout;
  logic [7:0]    sym_data;
  logic [39:0]   last_word;
  logic [CW-1:0] bytes_seen, frame_errs;

  a7_link_rx #(
    .TIMEOUT_CYC(TO),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serin        (serin),
    .req_start    (req_start),
    .sym_valid    (sym_valid),
    .sym_flag     (sym_flag),
    .sym_data     (sym_data),
    .resp_valid   (resp_valid),
    .last_word    (last_word),
    .resp_pending (resp_pending),
    .resp_timeout (resp_timeout),
    .bytes_seen   (bytes_seen),
    .frame_errs   (frame_errs)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit started = 1'b0;
  int nsv = 0;
  int nrv = 0;

  // Expected symbol completions, scheduled by the driver from wire timing.
  typedef struct {
    int       due;
    bit       flag;
    bit [7:0] data;
    bit       good;
  } exp_sym_t;
  exp_sym_t q[$];

  // Reference model state (values expected during the current cycle).
  bit        m_sv, m_flag, m_rv, m_pend, m_to;
  bit [7:0]  m_data;
  bit [39:0] m_last;
  int        m_bytes, m_errs, m_elapsed;
  bit [7:0]  resp_bytes[$];
  bit        p_sv, p_flag;
  bit [7:0]  p_data;
  exp_sym_t  e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response word = the bytes gathered since the last response, newest last,
  // keeping only what fits in 40 bits.
  function automatic bit [39:0] make_word(input bit [7:0] last_byte);
    bit [39:0] w;
    w = '0;
    foreach (resp_bytes[i]) w = (w << 8) | 40'(resp_bytes[i]);
    w = (w << 8) | 40'(last_byte);
    return w;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started = 1'b1;
      m_sv = 0; m_flag = 0; m_data = 0; m_rv = 0; m_pend = 0; m_to = 0;
      m_last = 0; m_bytes = 0; m_errs = 0; m_elapsed = 0;
      resp_bytes.delete();
    end else begin
      p_sv = m_sv; p_flag = m_flag; p_data = m_data;
      m_rv = 0;
      if (req_start) begin
        m_last = 0; resp_bytes.delete(); m_pend = 1; m_to = 0; m_elapsed = 0;
      end else begin
        if (p_sv) begin
          if (p_flag) begin
            m_last = make_word(p_data);
            resp_bytes.delete();
            m_rv = 1;
            m_pend = 0;
          end else begin
            resp_bytes.push_back(p_data);
            if (resp_bytes.size() > 4) void'(resp_bytes.pop_front());
          end
        end
        if (m_pend && !(p_sv && p_flag)) begin
          m_elapsed++;
          if (m_elapsed == TO) begin
            m_to = 1;
            m_pend = 0;
          end
        end
      end
      m_sv = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.good) begin
          m_sv = 1; m_flag = e.flag; m_data = e.data;
          m_bytes = (m_bytes + 1) % (1 << CW);
        end else begin
          m_errs = (m_errs + 1) % (1 << CW);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("sym_valid", sym_valid, m_sv);
      if (m_sv) begin
        chk("sym_flag", sym_flag, m_flag);
        chk("sym_data", sym_data, m_data);
      end
      chk("resp_valid", resp_valid, m_rv);
      chk("last_word", last_word, m_last);
      chk("resp_pending", resp_pending, m_pend);
      chk("resp_timeout", resp_timeout, m_to);
      chk("bytes_seen", bytes_seen, m_bytes);
      chk("frame_errs", frame_errs, m_errs);
      if (sym_valid === 1'b1) nsv++;
      if (resp_valid === 1'b1) nrv++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      serin = 1'b0;
    end
  endtask

  task automatic send_sym(input bit flag, input bit [7:0] data, input bit [1:0] stop);
    logic [11:0] w;
    exp_sym_t    x;
    w = {1'b1, flag, data, stop};
    for (int i = 11; i >= 0; i--) begin
      tick();
      serin = w[i];
    end
    x.due  = cyc + 2;
    x.flag = flag;
    x.data = data;
    x.good = (stop == 2'b00);
    q.push_back(x);
  endtask

  task automatic pulse_req();
    tick();
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    serin = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int nsv0, nrv0, rcyc;
  bit [3:0] part;

  initial begin
    // 1: reset then idle line
    tick();
    tick();
    reset = 1'b0;
    idle(30);
    @(negedge clk);
    chk("t1_bytes", bytes_seen, 0);
    chk("t1_errs", frame_errs, 0);
    chk("t1_no_sym", nsv, 0);
    chk("t1_last_word", last_word, 40'h0);

    // 2: request with three back-to-back symbols
    pulse_req();
    @(negedge clk);
    chk("t2_pending_set", resp_pending, 1);
    nsv0 = nsv; nrv0 = nrv;
    send_sym(1'b0, 8'h12, 2'b00);
    send_sym(1'b0, 8'h34, 2'b00);
    send_sym(1'b1, 8'h01, 2'b00);
    idle(5);
    @(negedge clk);
    chk("t2_sym_count", nsv - nsv0, 3);
    chk("t2_resp_count", nrv - nrv0, 1);
    chk("t2_last_word", last_word, 40'h00_0012_3401);
    chk("t2_pending_clr", resp_pending, 0);
    chk("t2_bytes", bytes_seen, 3);

    // 3: overflow of the word, unsolicited response
    do_reset();
    idle(3);
    for (int i = 0; i < 6; i++) send_sym(1'b0, 8'hA1 + 8'(i), 2'b00);
    send_sym(1'b1, 8'h07, 2'b00);
    idle(5);
    @(negedge clk);
    chk("t3_last_word", last_word, 40'hA3A4A5A607);
    chk("t3_bytes", bytes_seen, 7);

    // 4: bad stop bits, then a good symbol
    nsv0 = nsv;
    send_sym(1'b0, 8'h5A, 2'b10);
    idle(3);
    @(negedge clk);
    chk("t4_errs", frame_errs, 1);
    chk("t4_no_sym", nsv - nsv0, 0);
    send_sym(1'b0, 8'hC3, 2'b00);
    idle(3);
    @(negedge clk);
    chk("t4_recover_sym", nsv - nsv0, 1);
    chk("t4_bytes", bytes_seen, 8);

    // 5: timeout
    pulse_req();
    idle(TO + 3);
    @(negedge clk);
    chk("t5_timeout", resp_timeout, 1);
    chk("t5_pending", resp_pending, 0);
    chk("t5_last_word", last_word, 40'h0);

    // req_start on the same cycle as a flagged sym_valid: request wins
    nrv0 = nrv;
    send_sym(1'b1, 8'h55, 2'b00);
    tick();
    tick();
    req_start = 1'b1;
    rcyc = cyc;
    tick();
    req_start = 1'b0;
    @(negedge clk);
    chk("tA_timeout_clr", resp_timeout, 0);
    chk("tA_pending", resp_pending, 1);
    chk("tA_last_word", last_word, 40'h0);
    chk("tA_no_resp", nrv - nrv0, 0);
    chk("tA_bytes", bytes_seen, 9);

    // flagged symbol on the timeout cycle: symbol wins
    while (cyc < rcyc + int'(TO) - 14) tick();
    send_sym(1'b1, 8'h66, 2'b00);
    idle(5);
    @(negedge clk);
    chk("tB_timeout", resp_timeout, 0);
    chk("tB_pending", resp_pending, 0);
    chk("tB_last_word", last_word, 40'h66);
    chk("tB_resp", nrv - nrv0, 1);

    // 6: reset mid-symbol
    part = 4'b1010;
    tick(); serin = 1'b1;
    tick(); serin = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      tick();
      serin = part[i];
    end
    do_reset();
    idle(4);
    nrv0 = nrv;
    send_sym(1'b1, 8'h9C, 2'b00);
    idle(5);
    @(negedge clk);
    chk("t6_bytes", bytes_seen, 1);
    chk("t6_errs", frame_errs, 0);
    chk("t6_resp", nrv - nrv0, 1);
    chk("t6_last_word", last_word, 40'h9C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
